cdc_bus_rx_ctrl: RTL and testbench
==================================

Name: cdc_bus_rx_ctrl

Overview:
- Receive-side controller for a multi-bit bus crossing into the clk domain using a 2-phase (toggle) req/ack handshake.
- Only the 1-bit request toggle passes through a flop synchronizer chain. The S-bit bus is captured once, while the sender holds it stable, so multi-bit values never pass through flop synchronizers.
- Presents each captured word on a valid/ready interface, returns an ack toggle to the sender, and tracks transfer count and protocol errors.

Parameters:
- S, 12, data bus width in bits (1..64)
- SYNC_STAGES, 2, flops in the request synchronizer chain (2..4)
- CNT_W, 16, transfer counter width

Ports:
- clk  input  1  destination-domain clock
- rst  input  1  reset, asynchronous, active-high
- async_req_tgl  input  1  sender request toggle, asynchronous to clk
- async_data  input  S  sender data bus; held stable from req toggle until matching ack toggle
- ack_tgl  output  1  acknowledge toggle back to sender
- out_valid  output  1  captured word available
- out_ready  input  1  downstream accepts word
- out_data  output  S  captured word
- busy  output  1  high while a word is held (PRESENT state)
- xfer_cnt  output  CNT_W  completed transfers, wraps
- proto_err  output  1  sticky protocol-violation flag
- async_par  input  1  even parity of async_data (only with CDC_RX_PARITY_EN)
- par_err  output  1  sticky parity error (only with CDC_RX_PARITY_EN)

Behaviour:
- Reset values:
  - All sync flops, req_seen, ack_tgl, out_valid, busy, proto_err and par_err = 0.
  - out_data = 0; xfer_cnt = 0; state = IDLE.
  - Sender must be reset together with this block so both toggles restart at 0.
- Synchronizer: async_req_tgl passes through SYNC_STAGES flops; the last-stage output is req_sync.
- Edge detect: req_edge = req_sync XOR req_seen (combinational).
- State IDLE:
  - On req_edge: out_data <= async_data, req_seen <= req_sync, out_valid <= 1, go to PRESENT.
  - Otherwise hold.
- State PRESENT:
  - out_valid = busy = 1; out_data is frozen.
  - On out_valid && out_ready: out_valid <= 0, ack_tgl <= ~ack_tgl, xfer_cnt <= xfer_cnt + 1 (mod 2^CNT_W), go to IDLE.
- Latency:
  - Toggle first sampled at edge k → out_valid high after edge k+SYNC_STAGES.
  - Handshake accepted at edge m → ack_tgl changes after edge m.
- Back-to-back: a new edge can be seen in IDLE on the cycle after the return to IDLE. Minimum receive-side turnaround is 1 cycle, excluding the sender's own ack synchronisation.
- Protocol violation:
  - req_edge while in PRESENT means the sender toggled before receiving ack.
  - Effects: proto_err <= 1 (sticky until rst), req_seen <= req_sync (edge consumed), held data not overwritten, no extra ack.
- out_ready while out_valid = 0 is ignored.
- Reset mid-transfer: the word is lost, ack is not returned, and all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: CDC_RX_PARITY_EN
- Defined:
  - async_par and par_err ports exist.
  - At capture, parity of {async_data, async_par} is checked; odd parity sets par_err (sticky until rst).
  - The word is still presented and acknowledged.
- Undefined: both ports absent, no parity logic, behaviour otherwise identical.

Decomposition:
- Package cdc_pkg:
  - state enum {IDLE, PRESENT}
  - constants SYNC_STAGES_MIN = 2, SYNC_STAGES_MAX = 4
  - default width constants
- Sub-module cdc_sync_chain:
  - Single-bit, SYNC_STAGES-deep, async-reset flop chain.
  - Instantiated once for async_req_tgl; reused by the matching sender-side controller for ack.

Test Plan:
- Reset, then toggle async_req_tgl 0→1 with async_data = 12'hA5C, out_ready = 1 → out_valid pulses after 2 clk, out_data = 12'hA5C, ack_tgl = 1, xfer_cnt = 1.
- out_ready = 0 for 10 cycles after capture of 12'h3F0 → out_valid and busy held, out_data stable, ack_tgl unchanged; raise out_ready → single ack toggle, xfer_cnt increments once.
- Sender toggles req again while PRESENT → proto_err = 1, out_data keeps first word, only one ack toggle after acceptance.
- Assert rst while PRESENT → all outputs 0 asynchronously; next valid handshake transfers 12'h001 normally.
- Preload xfer_cnt to 16'hFFFF via 65535 transfers, or use CNT_W = 4 with 16 transfers → counter wraps to 0.
- With CDC_RX_PARITY_EN: data 12'h001 with async_par = 0 → par_err = 1, word still delivered; with async_par = 1 → par_err stays 0.

Source files
------------

// File: rtl/cdc_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pkg
// Shared types and constants for the toggle-handshake bus CDC controllers.
//   rx_state_e       : receive controller state (IDLE / PRESENT)
//   SYNC_STAGES_MIN  : shallowest allowed request synchronizer
//   SYNC_STAGES_MAX  : deepest allowed request synchronizer
//   DEF_*            : default parameter values for the controllers
// Optional feature macro used by the controllers: CDC_RX_PARITY_EN
// -----------------------------------------------------------------------------
package cdc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } rx_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  localparam int DEF_S           = 12;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/cdc_sync_chain.sv
// -----------------------------------------------------------------------------
// cdc_sync_chain
// Single-bit flop synchronizer, STAGES flops deep, asynchronous active-high
// reset. Only ever used for toggle signals; never for multi-bit buses.
// Ports:
//   clk     : destination clock
//   rst     : asynchronous active-high reset (all flops to 0)
//   async_i : signal asynchronous to clk
//   sync_o  : output of the last flop in the chain
// -----------------------------------------------------------------------------
module cdc_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  // sync_q[0] is the metastability-catching flop; the rest only re-time it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_bus_rx_ctrl.sv
// -----------------------------------------------------------------------------
// cdc_bus_rx_ctrl
// Receive side of a 2-phase (toggle) req/ack bus crossing into clk. Only the
// request toggle is synchronized; the S-bit bus is captured once while the
// sender holds it stable. The word is presented on valid/ready, an ack toggle
// is returned on acceptance, transfers are counted and protocol errors are
// flagged.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   async_req_tgl   : sender request toggle (asynchronous)
//   async_data[S]   : sender bus, stable from req toggle to matching ack
//   ack_tgl         : acknowledge toggle back to the sender
//   out_valid/ready : downstream handshake, out_data[S] the captured word
//   busy            : a word is being held
//   xfer_cnt[CNT_W] : completed transfers, wraps
//   proto_err       : sticky, sender toggled req before getting ack
//   async_par       : even parity of async_data   (CDC_RX_PARITY_EN only)
//   par_err         : sticky parity error flag    (CDC_RX_PARITY_EN only)
// Optional feature macro: CDC_RX_PARITY_EN
// -----------------------------------------------------------------------------
module cdc_bus_rx_ctrl
  import cdc_pkg::*;
#(
  parameter int S           = DEF_S,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             async_req_tgl,
  input  logic [S-1:0]     async_data,
  output logic             ack_tgl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [S-1:0]     out_data,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt,
`ifdef CDC_RX_PARITY_EN
  input  logic             async_par,
  output logic             par_err,
`endif
  output logic             proto_err
);

  rx_state_e        state_q, state_d;
  logic             req_seen_q, req_seen_d;
  logic [S-1:0]     data_q, data_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             proto_err_q, proto_err_d;
  logic             req_sync;
  logic             req_edge;

  cdc_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (async_req_tgl),
    .sync_o  (req_sync)
  );

  // A new request is any difference between the synchronized toggle and the
  // last toggle level this side has consumed.
  assign req_edge = req_sync ^ req_seen_q;

`ifdef CDC_RX_PARITY_EN
  logic par_err_q, par_err_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_seen_q  <= 1'b0;
      data_q      <= '0;
      ack_q       <= 1'b0;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_seen_q  <= req_seen_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef CDC_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    req_seen_d  = req_seen_q;
    data_d      = data_q;
    ack_d       = ack_q;
    cnt_d       = cnt_q;
    proto_err_d = proto_err_q;
`ifdef CDC_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_edge) begin
          // The bus has been stable since before the toggle entered the
          // synchronizer, so sampling it here is safe.
          data_d     = async_data;
          req_seen_d = req_sync;
          state_d    = PRESENT;
`ifdef CDC_RX_PARITY_EN
          par_err_d  = par_err_q | (^{async_data, async_par});
`endif
        end
      end
      PRESENT: begin
        // Early toggle from the sender: flag it and consume the edge so it
        // is not mistaken for a fresh word later; held data is untouched.
        if (req_edge) begin
          proto_err_d = 1'b1;
          req_seen_d  = req_sync;
        end
        if (out_ready) begin
          ack_d   = ~ack_q;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_valid = (state_q == PRESENT);
  assign busy      = (state_q == PRESENT);
  assign out_data  = data_q;
  assign ack_tgl   = ack_q;
  assign xfer_cnt  = cnt_q;
  assign proto_err = proto_err_q;
`ifdef CDC_RX_PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_cdc_bus_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cdc_bus_rx_ctrl
// Self-checking bench for cdc_bus_rx_ctrl. A sender model issues words and
// pushes each expected word into a queue; a monitor pops and compares every
// accepted word and the transfer count. Directed tests cover latency,
// backpressure, protocol violation, asynchronous reset, counter wrap and
// (with CDC_RX_PARITY_EN) parity; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_cdc_bus_rx_ctrl;

  localparam int S           = 12;
  localparam int SYNC_STAGES = 2;
  localparam int TB_CNT_W    = 4;

  logic                clk;
  logic                rst;
  logic                async_req_tgl;
  logic [S-1:0]        async_data;
  logic                ack_tgl;
  logic                out_valid;
  logic                out_ready;
  logic [S-1:0]        out_data;
  logic                busy;
  logic [TB_CNT_W-1:0] xfer_cnt;
  logic                proto_err;
  logic                async_par;
  logic                par_err;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  logic [S-1:0] exp_q[$];
  bit rand_done;

  cdc_bus_rx_ctrl #(
    .S           (S),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .async_req_tgl (async_req_tgl),
    .async_data    (async_data),
    .ack_tgl       (ack_tgl),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy),
    .xfer_cnt      (xfer_cnt),
`ifdef CDC_RX_PARITY_EN
    .async_par     (async_par),
    .par_err       (par_err),
`endif
    .proto_err     (proto_err)
  );

`ifndef CDC_RX_PARITY_EN
  assign par_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted word must be the oldest outstanding one, and the
  // count shown before acceptance equals accepted-so-far modulo 2^CNT_W.
  initial begin
    logic [S-1:0] w;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        exp_cnt = 0;
      end else if (out_valid && out_ready) begin
        check("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(w));
          check("xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt % (1 << TB_CNT_W)));
          $display("xfer %0d: data=%03h cnt=%0d", exp_cnt, out_data, xfer_cnt);
        end
        exp_cnt++;
      end
    end
  end

  task automatic send(input logic [S-1:0] d, input logic p);
    @(negedge clk);
    async_data    = d;
    async_par     = p;
    async_req_tgl = ~async_req_tgl;
    exp_q.push_back(d);
  endtask

  task automatic wait_ack();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack_tgl == async_req_tgl) begin
        ok = 1'b1;
        break;
      end
    end
    check("ack_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("valid_timeout", 64'(ok), 64'd1);
  endtask

  // Receiver and sender are reset together: sender toggle returns to 0.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    async_req_tgl = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [S-1:0] d;
    rst           = 1'b1;
    async_req_tgl = 1'b0;
    async_data    = '0;
    async_par     = 1'b0;
    out_ready     = 1'b0;
    rand_done     = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_ack",       64'(ack_tgl),   64'd0);
    check("rst_cnt",       64'(xfer_cnt),  64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_par_err",   64'(par_err),   64'd0);

    // A: latency of SYNC_STAGES edges, immediate acceptance
    out_ready = 1'b1;
    send(12'hA5C, ^12'hA5C);
    for (int i = 0; i < SYNC_STAGES; i++) begin
      @(negedge clk);
      check("lat_valid_low", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    check("lat_valid_high", 64'(out_valid), 64'd1);
    check("A_out_data", 64'(out_data), 64'hA5C);
    @(negedge clk);
    check("A_ack", 64'(ack_tgl), 64'd1);
    check("A_cnt", 64'(xfer_cnt), 64'd1);
    check("A_valid_drop", 64'(out_valid), 64'd0);

    // B: backpressure holds the word
    out_ready = 1'b0;
    send(12'h3F0, ^12'h3F0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("B_valid_held", 64'(out_valid), 64'd1);
      check("B_busy_held",  64'(busy),      64'd1);
      check("B_data_held",  64'(out_data),  64'h3F0);
      check("B_ack_held",   64'(ack_tgl),   64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("B_ack", 64'(ack_tgl), 64'd0);
    check("B_cnt", 64'(xfer_cnt), 64'd2);
    check("B_valid_drop", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("B_single_ack", 64'(ack_tgl), 64'd0);

    // C: sender toggles again while the word is still held
    out_ready = 1'b0;
    send(12'h111, ^12'h111);
    wait_valid();
    @(negedge clk);
    async_data    = 12'h222;
    async_req_tgl = ~async_req_tgl;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    check("C_proto_err", 64'(proto_err), 64'd1);
    check("C_data_kept", 64'(out_data),  64'h111);
    check("C_ack_held",  64'(ack_tgl),   64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("C_ack", 64'(ack_tgl), 64'd1);
    check("C_cnt", 64'(xfer_cnt), 64'd3);
    repeat (5) @(negedge clk);
    check("C_no_extra_valid", 64'(out_valid), 64'd0);
    check("C_no_extra_ack",   64'(ack_tgl),   64'd1);
    check("C_cnt_idle_ready", 64'(xfer_cnt),  64'd3);
    check("C_proto_sticky",   64'(proto_err), 64'd1);

    // D: asynchronous reset while a word is held
    do_reset();
    out_ready = 1'b0;
    send(12'h5AA, ^12'h5AA);
    wait_valid();
    #2;
    rst = 1'b1;
    #1;
    check("D_valid",     64'(out_valid), 64'd0);
    check("D_busy",      64'(busy),      64'd0);
    check("D_ack",       64'(ack_tgl),   64'd0);
    check("D_cnt",       64'(xfer_cnt),  64'd0);
    check("D_proto_err", 64'(proto_err), 64'd0);
    check("D_out_data",  64'(out_data),  64'd0);
    exp_q.delete();
    async_req_tgl = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    send(12'h001, ^12'h001);
    wait_ack();
    check("D_after_cnt", 64'(xfer_cnt), 64'd1);

    // E: counter wraps after 2^CNT_W transfers
    for (int i = 0; i < 15; i++) begin
      d = S'($urandom);
      send(d, ^d);
      wait_ack();
    end
    check("E_wrap", 64'(xfer_cnt), 64'd0);

`ifdef CDC_RX_PARITY_EN
    // Parity: odd overall parity sets the sticky flag, word still delivered
    do_reset();
    out_ready = 1'b1;
    send(12'h001, 1'b0);
    wait_ack();
    check("P_bad_par", 64'(par_err), 64'd1);
    check("P_bad_cnt", 64'(xfer_cnt), 64'd1);
    do_reset();
    check("P_rst_par", 64'(par_err), 64'd0);
    send(12'h001, 1'b1);
    wait_ack();
    check("P_good_par", 64'(par_err), 64'd0);
`endif

    // Randomized legal traffic with random backpressure
    do_reset();
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          d = S'($urandom);
          send(d, ^d);
          wait_ack();
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("R_queue_empty", 64'(exp_q.size()), 64'd0);
    check("R_proto_err",   64'(proto_err),    64'd0);
    check("R_par_err",     64'(par_err),      64'd0);
    check("R_cnt",         64'(xfer_cnt),     64'(60 % (1 << TB_CNT_W)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
